// File: rtl/adc_axil_pkg.sv
// adc_axil_pkg: shared register map, response codes and FSM states for the ADC AXI-Lite reader
package adc_axil_pkg;
  localparam logic [4:0] OFF_CR       = 5'h00;
  localparam logic [4:0] OFF_SR       = 5'h04;
  localparam logic [4:0] OFF_DSIZE    = 5'h08;
  localparam logic [4:0] OFF_CNT_LO   = 5'h0C;
  localparam logic [4:0] OFF_CNT_HI   = 5'h10;
  localparam logic [4:0] OFF_LS_START = 5'h14;
  localparam logic [4:0] OFF_LS_STOP  = 5'h18;
  localparam logic [4:0] OFF_RSVD     = 5'h1C;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam int BANK_STRIDE = 32;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/adc_axil_sticky_sr.sv
// adc_axil_sticky_sr: sticky status register, clear-on-read with set winning over clear
module adc_axil_sticky_sr #(
  parameter int SR_W = 8
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic [SR_W-1:0] set,
  input  logic [SR_W-1:0] clr,
  output logic [SR_W-1:0] q
);
  // a set coincident with a clear keeps the bit so the event shows on the next read
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) q <= '0;
    else q <= (q & ~clr) | set;
  end
endmodule

// File: rtl/adc_input_axil_reader.sv
// adc_input_axil_reader: per-channel AXI-Lite read bank with sticky SR and coherent 64-bit counters (option: ADC_AXIL_SLVERR_EN)
module adc_input_axil_reader
  import adc_axil_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int N_CH   = 2,
  parameter int SR_W   = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [ADDR_W-1:0]    ARADDR,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [31:0]          RDATA,
  output logic [1:0]           RRESP,
  output logic                 RVALID,
  input  logic                 RREADY,
  input  logic [N_CH*32-1:0]   ch_cr,
  input  logic [N_CH*32-1:0]   ch_dsize,
  input  logic [N_CH*64-1:0]   ch_cnt,
  input  logic [N_CH*16-1:0]   ch_ls_start_thr,
  input  logic [N_CH*16-1:0]   ch_ls_stop_thr,
  input  logic [N_CH*SR_W-1:0] ch_sr_set,
  output logic [N_CH*SR_W-1:0] sr_q
);
  localparam int CHW = ADDR_W - $clog2(BANK_STRIDE);
  state_t state_q, state_d;
  logic [CHW-1:0] ch_sel;
  logic [4:0] off;
  logic [N_CH-1:0] ch_hit;
  logic [N_CH*SR_W-1:0] sr_clr;
  logic [N_CH*32-1:0] shadow;
  logic hs, ok;
  logic [31:0] rd_data, cr, ds, cnt_lo, sh;
  logic [15:0] ls_start, ls_stop;
  logic [SR_W-1:0] sr;
  logic [1:0] rd_resp;
  assign ch_sel = ARADDR[ADDR_W-1:ADDR_W-CHW];
  assign off = ARADDR[4:0];
  assign hs = ARREADY & ARVALID;
  assign ok = (ch_sel < CHW'(N_CH)) & (ARADDR[1:0] == 2'b00);
`ifdef ADC_AXIL_SLVERR_EN
  assign rd_resp = ok ? RESP_OKAY : RESP_SLVERR;
`else
  assign rd_resp = RESP_OKAY;
`endif
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_hit[k] = ch_sel == CHW'(k);
    assign sr_clr[k*SR_W+:SR_W] = {SR_W{hs & ok & ch_hit[k] & (off == OFF_SR)}};
    adc_axil_sticky_sr #(.SR_W(SR_W)) u_sr (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .set     (ch_sr_set[k*SR_W+:SR_W]),
      .clr     (sr_clr[k*SR_W+:SR_W]),
      .q       (sr_q[k*SR_W+:SR_W])
    );
  end
  // channel select then register mux; illegal accesses read as zero
  always_comb begin
    cr = '0;
    ds = '0;
    cnt_lo = '0;
    sh = '0;
    ls_start = '0;
    ls_stop = '0;
    sr = '0;
    rd_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_hit[k]) begin
        cr = ch_cr[32*k+:32];
        ds = ch_dsize[32*k+:32];
        cnt_lo = ch_cnt[64*k+:32];
        sh = shadow[32*k+:32];
        ls_start = ch_ls_start_thr[16*k+:16];
        ls_stop = ch_ls_stop_thr[16*k+:16];
        sr = sr_q[SR_W*k+:SR_W];
      end
    end
    case (off)
      OFF_CR:       rd_data = cr;
      OFF_SR:       rd_data = 32'(sr);
      OFF_DSIZE:    rd_data = ds;
      OFF_CNT_LO:   rd_data = cnt_lo;
      OFF_CNT_HI:   rd_data = sh;
      OFF_LS_START: rd_data = {16'h0, ls_start};
      OFF_LS_STOP:  rd_data = {16'h0, ls_stop};
      OFF_RSVD:     rd_data = '0;
      default:      rd_data = '0;
    endcase
    if (!ok) rd_data = '0;
  end
  // next state: accept an address in IDLE, hold the response until RREADY
  always_comb begin
    state_d = state_q == IDLE ? (hs ? RESP : IDLE) : (RREADY ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else state_q <= state_d;
  end
  // registered handshake outputs and read data captured on the AR handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ARREADY <= 1'b0;
      RVALID <= 1'b0;
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else begin
      ARREADY <= state_d == IDLE;
      RVALID <= state_d == RESP;
      if (hs) begin
        RDATA <= rd_data;
        RRESP <= rd_resp;
      end
    end
  end
  // CNT_LO reads snapshot the upper counter half for a later CNT_HI read
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) shadow <= '0;
    else for (int k = 0; k < N_CH; k++)
      if (hs & ok & ch_hit[k] & (off == OFF_CNT_LO)) shadow[32*k+:32] <= ch_cnt[64*k+32+:32];
  end
endmodule

// File: doc/adc_input_axil_reader.md
# adc_input_axil_reader

Multi-channel AXI4-Lite read slave for the ADC input subsystem. It exposes one register bank per ADC channel and decodes the channel index and register offset from a latched read address. Unmapped and unaligned accesses are flagged, sticky per-channel status bits clear on read, and 64-bit sample counters are read with hi/lo snapshot coherence. It sits between the PS AXI interconnect and the per-channel acquisition cores.

## Interface
- ADDR_W, 12: AXI address width.
- N_CH, 2: number of ADC channels (1..8); bank stride 0x20 bytes.
- SR_W, 8: sticky status bits per channel (1..32).

- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low; clock ACLK.
- ARADDR  in  ADDR_W  read address.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RDATA  out  32  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- ch_cr  in  N_CH*32  per-channel control readback, ch k in [32k+31:32k].
- ch_dsize  in  N_CH*32  per-channel captured data size.
- ch_cnt  in  N_CH*64  per-channel free-running sample counter.
- ch_ls_start_thr, ch_ls_stop_thr  in  N_CH*16 each  level-start/level-stop thresholds.
- ch_sr_set  in  N_CH*SR_W  single-cycle set pulses for sticky status bits.
- sr_q  out  N_CH*SR_W  current sticky status, for interrupt logic.

## Operation
- Address decode: ch = ARADDR[ADDR_W-1:5], off = ARADDR[4:0].
- Per-bank offsets:
  - 0x00 CR.
  - 0x04 SR (clear-on-read).
  - 0x08 DSIZE.
  - 0x0C CNT_LO: returns cnt[31:0] and loads cnt[63:32] into shadow[ch].
  - 0x10 CNT_HI: returns shadow[ch].
  - 0x14 LS_START_THR, zero-extended.
  - 0x18 LS_STOP_THR, zero-extended.
  - 0x1C reserved: reads 0, OKAY.
- Error accesses: ch >= N_CH, or ARADDR[1:0] != 0. These return RDATA=0 with RRESP=SLVERR, and have no side effects (no SR clear, no shadow load).
- Address and all read data are sampled on the AR handshake cycle. Later ARADDR changes have no effect.
- Sticky SR update per bit: next = (q & ~clr) | set.
  - clr is set only on the handshake cycle of a valid SR read of that channel.
  - RDATA carries q before the update.
  - A set pulse coincident with the clear leaves the bit at 1, so the event is reported on the next read.
- State machine:
  - IDLE: ARREADY=1. On ARVALID, capture RDATA/RRESP and go to RESP.
  - RESP: RVALID=1, ARREADY=0. On RREADY, go to IDLE.

## Timing
- Every output is registered.
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=00, sr_q=0, all shadows=0.
- ARREADY rises on the first ACLK edge after ARESETN deasserts.
- AR handshake at edge n → RVALID=1 from edge n+1. RDATA/RRESP are stable while RVALID=1.
- R handshake at edge m → RVALID=0 and ARREADY=1 from edge m+1. Peak throughput is one read per 2 cycles.
- RREADY held low stalls indefinitely in RESP. No new address is accepted while stalled.
- Reset asserted mid-transaction immediately (asynchronously) drops RVALID and ARREADY. The pending read is discarded, sticky bits clear, and no response is issued after reset.
- Counter coherence: the CNT_LO/CNT_HI pair is consistent for any gap between the two reads, provided no other CNT_LO read of the same channel intervenes.

## Configuration
- Macro: ADC_AXIL_SLVERR_EN.
- Defined: out-of-range and unaligned accesses return SLVERR as described above.
- Undefined: the same accesses return RDATA=0 with OKAY, still with no side effects. RRESP is then always 00.

## Structure
- Package adc_axil_pkg holds:
  - register offset localparams (OFF_CR … OFF_RSVD);
  - RESP_OKAY/RESP_SLVERR;
  - BANK_STRIDE;
  - the state enum typedef {IDLE, RESP}.
- Sub-module adc_axil_sticky_sr: one SR_W-bit sticky register with set/clear inputs and the set-wins rule, instantiated N_CH times via generate.
- The top module holds the FSM, the decode, the read mux and the N_CH×32 shadow registers.

## Test plan
- Reset release, then read 0x008 with ch_dsize ch0=0x0000_1234 → ARREADY=1 at cycle 1; RVALID one cycle after handshake, RDATA=0x1234, RRESP=00.
- Pulse ch_sr_set ch1 bit0; read 0x024 → 0x01. Read again → 0x00. Repeat with the pulse on the handshake cycle → first read 0x00, second 0x01.
- ch_cnt ch0=0x0000_0005_FFFF_FFFF; read 0x00C → 0xFFFF_FFFF. Change counter to 0x6_0000_0000, then read 0x010 → 0x0000_0005.
- N_CH=2, read 0x040 and 0x005 → RDATA 0, RRESP=10; sr_q unchanged. Without the macro → RRESP=00.
- Hold RREADY low 10 cycles → RVALID and RDATA stable, ARREADY=0 throughout; ARREADY=1 one cycle after RREADY.
- Assert ARESETN low while RVALID=1 → RVALID=0 immediately; sr_q=0; no spurious R beat after release.
